arb_mux: RTL and testbench
==========================

# arb_mux

Round-robin arbitrating multiplexer: merges 2**CTRL independent valid/ready request streams into one registered valid/ready output stream. Each output beat carries the index of its source, so the downstream `demux` can route responses back on the same `ctrl` encoding. Sits in front of shared resources (memory port, shared bus) wherever several requesters contend.

## Interface
- `CTRL`, 2, width of source index; number of inputs N = 2**CTRL
- `DATA_WIDTH`, 32, payload width

- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high
- `in_valid`  in  N  per-source request valid, bit i = source i
- `in_data`  in  DATA_WIDTH x N (unpacked `[2**CTRL]`)  per-source payload
- `in_ready`  out  N  per-source accept, one-hot or zero
- `out_valid`  out  1  output beat valid (registered)
- `out_data`  out  DATA_WIDTH  payload of accepted beat (registered)
- `out_id`  out  CTRL  source index of accepted beat (registered)
- `out_ready`  in  1  downstream accept

## Operation
- State: output slot (`out_valid`, `out_data`, `out_id`) and priority pointer `ptr` (CTRL bits).
- `load = !out_valid || out_ready`: the slot can take a new beat this cycle.
- Grant: scan sources in order ptr, ptr+1, …, ptr+N-1 (mod N); the first with `in_valid` set wins.
- `in_ready[i] = load && grant == i`. All other bits 0. `in_ready` is 0 for every source when `load` is 0 or no source is valid.
- A transfer on source i (`in_valid[i] && in_ready[i]`) does all of the following at the clock edge:
  - `out_data <= in_data[i]`
  - `out_id <= i`
  - `out_valid <= 1`
  - `ptr <= (i+1) mod N`
- When `load` is 1 and no source is valid: `out_valid <= 0`. `out_data`/`out_id` hold their values. `ptr` holds.
- When `load` is 0 (stall, `out_valid && !out_ready`): the slot holds all fields and `ptr` holds.
- Pointer arithmetic is CTRL bits wide and wraps naturally: after a grant to N-1, `ptr` becomes 0.
- Fairness: a source that keeps `in_valid` asserted is granted within N transfers.
- Upstream rule: `in_valid`/`in_data` must not depend on `in_ready`. Once `in_valid` is raised it is held stable until accepted.
- Downstream rule: the block holds `out_valid`/`out_data`/`out_id` stable while `out_valid && !out_ready`.

## Timing
- Reset (async assert, sync release): `out_valid=0`, `out_data=0`, `out_id=0`, `ptr=0`.
  - `in_ready` = 0 while reset is asserted.
  - Reset mid-operation drops any beat held in the slot. No replay.
- Latency: input accepted at edge k appears on `out_*` from after edge k. One cycle, input to output.
- Throughput: one beat per cycle while `out_ready` is held at 1.
  - Back-to-back grants to different sources are allowed.
  - The same source is regranted only if no other source is valid.
- Combinational paths:
  - `in_valid` → `in_ready`
  - `out_ready` → `in_ready`
  - None to `out_*`.
- Simultaneous consume and load (`out_valid && out_ready` plus a valid source): the new beat replaces the old at the same edge, with no bubble.

## Test plan
Parameters for all scenarios: CTRL=2, DATA_WIDTH=32.

- **Reset values.** Hold `reset`=1 with all `in_valid`=4'b1111.
  - Required: `in_ready`=0, `out_valid`=0, `out_data`=0, `out_id`=0.
  - After release with `out_ready`=1: the first grant goes to source 0.
- **Round-robin rotation.** All four valid continuously, `in_data[i]`=32'hA0+i, `out_ready`=1.
  - Required: `out_id` sequence 0,1,2,3,0,1 on consecutive cycles; `out_data` 0xA0,0xA1,0xA2,0xA3,0xA0,0xA1.
- **Sparse requests with wrap-around.** Only sources 3 and 1 valid, `ptr`=0.
  - Required: grant to 1, then 3, then 1 (wraps past 0 and 2).
  - A lone source 2 asserted every cycle is granted every cycle.
- **Backpressure.** `out_valid`=1 holding `out_id`=2, `out_data`=0x55; `out_ready`=0 for 3 cycles while sources 0 and 3 are valid.
  - Required: `in_ready`=0 throughout; `out_*` stable.
  - On the cycle `out_ready`=1: source 3 is granted in the same cycle (`ptr`=3), and the next beat shows `out_id`=3 with no bubble.
- **Idle drain.** Accept one beat, then all `in_valid`=0 with `out_ready`=1.
  - Required: `out_valid` falls the next cycle; `out_data`/`out_id` retain their last values.
- **Reset mid-stall.** Assert `reset` asynchronously while `out_valid`=1, `out_ready`=0.
  - Required: `out_valid` drops immediately without waiting for `clk`.
  - The beat is lost; `ptr` returns to 0.

Source files
------------

// File: rtl/arb_mux.sv
// Round-robin arbitrating mux: merges 2**CTRL valid/ready streams into one
// registered output slot tagged with the source index.
module arb_mux #(
  parameter int CTRL       = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2**CTRL-1:0]    in_valid,
  input  logic [DATA_WIDTH-1:0] in_data [2**CTRL],
  output logic [2**CTRL-1:0]    in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL-1:0]       out_id,
  input  logic                  out_ready
);
  localparam int N = 2**CTRL;

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CTRL-1:0]       id_q, id_d;
  logic [CTRL-1:0]       ptr_q, ptr_d;

  logic                  load;
  logic                  any_vld;
  logic [CTRL-1:0]       grant;
  logic [CTRL-1:0]       idx;

  assign load = !valid_q || out_ready;

  // Scan from the farthest offset down so the source nearest ptr wins last.
  always_comb begin
    grant   = ptr_q;
    any_vld = 1'b0;
    idx     = ptr_q;
    for (int k = N-1; k >= 0; k--) begin
      idx = ptr_q + CTRL'(k);
      if (in_valid[idx]) begin
        grant   = idx;
        any_vld = 1'b1;
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (load && any_vld && !reset) in_ready[grant] = 1'b1;
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    if (load) begin
      if (any_vld) begin
        valid_d = 1'b1;
        data_d  = in_data[grant];
        id_d    = grant;
        ptr_d   = grant + CTRL'(1);
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_id    = id_q;
endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: directed vectors with literal expectations plus a
// per-cycle comparison against a behavioural round-robin model.
module tb_arb_mux;
  localparam int CTRL = 2;
  localparam int N    = 4;
  localparam int DW   = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  in_valid = '0;
  logic [DW-1:0] in_data [N];
  logic [N-1:0]  in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [CTRL-1:0] out_id;
  logic          out_ready = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model of the slot and pointer.
  bit        m_valid = 0;
  int        m_data  = 0;
  int        m_id    = 0;
  int        m_ptr   = 0;

  arb_mux #(.CTRL(CTRL), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_id(out_id), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int first_valid(input logic [N-1:0] v, input int p);
    for (int off = 0; off < N; off++)
      if (v[(p + off) % N]) return (p + off) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] model_ready();
    int g;
    g = first_valid(in_valid, m_ptr);
    if (reset || (m_valid && !out_ready) || g < 0) return '0;
    return N'(1) << g;
  endfunction

  always @(posedge clk or posedge reset) begin
    int g;
    if (reset) begin
      m_valid = 0; m_data = 0; m_id = 0; m_ptr = 0;
    end else if (!m_valid || out_ready) begin
      g = first_valid(in_valid, m_ptr);
      if (g >= 0) begin
        m_valid = 1; m_data = int'(in_data[g]); m_id = g; m_ptr = (g + 1) % N;
      end else begin
        m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("mdl_in_ready",  32'(in_ready),  32'(model_ready()));
    chk("mdl_out_valid", 32'(out_valid), 32'(m_valid));
    chk("mdl_out_data",  out_data,       32'(m_data));
    chk("mdl_out_id",    32'(out_id),    32'(m_id));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input string name, input int id, input logic [31:0] data);
    tick();
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_id"},    32'(out_id),    32'(id));
    chk({name, "_data"},  out_data,       data);
  endtask

  initial begin
    for (int i = 0; i < N; i++) in_data[i] = 32'hA0 + 32'(i);
    // Reset values with all sources requesting.
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    #12;
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  out_data,       32'd0);
    chk("rst_out_id",    32'(out_id),    32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("first_grant", 32'(in_ready), 32'b0001);

    // Round-robin rotation.
    beat("rr0", 0, 32'hA0);
    beat("rr1", 1, 32'hA1);
    beat("rr2", 2, 32'hA2);
    beat("rr3", 3, 32'hA3);
    beat("rr4", 0, 32'hA0);
    beat("rr5", 1, 32'hA1);
    beat("rr6", 2, 32'hA2);
    beat("rr7", 3, 32'hA3);

    // Sparse requests from ptr=0.
    in_valid = 4'b1010;
    #1;
    chk("sparse_grant", 32'(in_ready), 32'b0010);
    beat("sp0", 1, 32'hA1);
    beat("sp1", 3, 32'hA3);
    beat("sp2", 1, 32'hA1);
    in_valid = 4'b0100;
    beat("lone0", 2, 32'hA2);
    beat("lone1", 2, 32'hA2);
    beat("lone2", 2, 32'hA2);

    // Backpressure with slot holding id 2 / 0x55, ptr=3.
    in_data[2] = 32'h55;
    beat("bp_fill", 2, 32'h55);
    in_valid   = 4'b1001;
    in_data[0] = 32'hB0;
    in_data[3] = 32'hB3;
    out_ready  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_id",    32'(out_id),    32'd2);
      chk("bp_hold_data",  out_data,       32'h55);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_grant", 32'(in_ready), 32'b1000);
    beat("bp_next", 3, 32'hB3);

    // Idle drain.
    in_valid = 4'b0001;
    beat("drain_last", 0, 32'hB0);
    in_valid = 4'b0000;
    tick();
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_id",    32'(out_id),    32'd0);
    chk("drain_data",  out_data,       32'hB0);

    // Reset in the middle of a stall.
    in_valid   = 4'b0100;
    in_data[2] = 32'h77;
    beat("stall_fill", 2, 32'h77);
    in_valid  = 4'b0000;
    out_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_data",  out_data,       32'd0);
    chk("midrst_id",    32'(out_id),    32'd0);
    #1;
    reset     = 1'b0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    #1;
    chk("midrst_ptr0", 32'(in_ready), 32'b0001);
    beat("post_rst", 0, 32'hB0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
